// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and shared memory port signals around the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_we;
    logic [DATA_W-1:0] d_req_wdata;
    logic [DATA_W/8-1:0] d_req_wstrb;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    modport master (
        input  if_req_valid, if_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb
    );
    modport slave (
        output if_req_valid, if_req_addr, d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, data first, fetch starvation-bounded
module mem_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
    state_t state, next_state;
    logic owner_d;
    logic [3:0] starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic fetch_pri, grant_d, grant_f, req_valid, rsp_hit;
    always_comb begin
        fetch_pri = starve_cnt == 4'(MAX_WAIT) && bus.if_req_valid;
        grant_d = rst_n && state == IDLE && bus.d_req_valid && !fetch_pri;
        grant_f = rst_n && state == IDLE && bus.if_req_valid && !grant_d;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    always_comb
        next_state = state == IDLE ? ((grant_d || grant_f) ? REQ : IDLE) :
                     state == REQ  ? (bus.mem_req_ready ? WAIT_RSP : REQ) :
                                     (bus.mem_rsp_valid ? IDLE : WAIT_RSP);
    always_comb begin
        busy = state != IDLE;
        req_valid = state == REQ;
        rsp_hit = state == WAIT_RSP && bus.mem_rsp_valid;
    end
    // a fetch capture clears we/wstrb so the memory never sees a stale store
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner_d <= 1'b0;
            starve_cnt <= 4'd0;
            addr_q <= '0;
            we_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (grant_d) begin
            owner_d <= 1'b1;
            addr_q <= bus.d_req_addr;
            we_q <= bus.d_req_we;
            wdata_q <= bus.d_req_wdata;
            wstrb_q <= bus.d_req_wstrb;
            starve_cnt <= !bus.if_req_valid ? 4'd0 : starve_cnt == 4'(MAX_WAIT) ? starve_cnt : starve_cnt + 4'd1;
        end else if (grant_f) begin
            owner_d <= 1'b0;
            addr_q <= bus.if_req_addr;
            we_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            starve_cnt <= 4'd0;
        end
    assign bus.if_req_ready  = grant_f;
    assign bus.d_req_ready   = grant_d;
    assign bus.if_rsp_valid  = rsp_hit && !owner_d;
    assign bus.d_rsp_valid   = rsp_hit && owner_d;
    assign bus.if_rsp_data   = bus.mem_rsp_data;
    assign bus.d_rsp_data    = bus.mem_rsp_data;
    assign bus.mem_req_valid = req_valid;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wstrb     = wstrb_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares a single memory port between the core's instruction-fetch requester and its load/store requester. It sits between the core and the unified memory model. It accepts one request at a time, with data access prioritised and fetch protected from starvation, drives the shared port through a request/response handshake, and routes each response back to its owner. There is exactly one outstanding transaction.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width (multiple of 8)
- MAX_WAIT, 4, consecutive data grants allowed while fetch waits (1..15)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  DATA_W  fetch read data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  ADDR_W  data address
- d_req_we  in  1  1 = store, 0 = load
- d_req_wdata  in  DATA_W  store data
- d_req_wstrb  in  DATA_W/8  store byte enables
- d_rsp_valid  out  1  data response pulse (load data or store ack)
- d_rsp_data  out  DATA_W  load data
- mem_req_valid  out  1  shared-port request
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_we, mem_wdata, mem_wstrb  out  ADDR_W/1/DATA_W/DATA_W/8  registered request fields
- mem_rsp_valid  in  1  memory response pulse
- mem_rsp_data  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT_RSP.
- **IDLE:** grant is combinational.
  - Data wins unless starve_cnt == MAX_WAIT and if_req_valid is high; in that case fetch wins.
  - Only the winner's ready is high. The other ready is 0, and both are 0 if neither is valid.
  - On valid & ready, capture addr, we, wdata and wstrb into the mem_* registers, set owner, and go to REQ.
  - A fetch capture forces we = 0 and wstrb = 0.
- **REQ:** mem_req_valid = 1 and fields are held stable. On mem_req_ready, go to WAIT_RSP.
- **WAIT_RSP:** on mem_rsp_valid:
  - The owner's rsp_valid = 1 for that cycle, and its rsp_data = mem_rsp_data (combinational).
  - Go to IDLE.
- Stores also require a mem_rsp_valid ack. d_rsp_data is don't-care on store acks.
- Responses have no backpressure. Requesters must sink the one-cycle pulse.
- mem_rsp_valid in IDLE or REQ is ignored and nothing is routed.
- **starve_cnt (4 bits):**
  - Incremented on a data grant while if_req_valid = 1.
  - Cleared on a fetch grant, or on a data grant while if_req_valid = 0.
  - Saturates at MAX_WAIT.
- Requesters must hold valid and fields until ready. The arbiter does not check this.

## Timing
- Reset (async assert, sync release by the surrounding reset tree) gives:
  - state = IDLE, owner = fetch, starve_cnt = 0.
  - All mem_* registers 0.
  - busy = 0, mem_req_valid = 0.
  - All rsp_valid = 0; both readies forced 0 while rst_n = 0.
- Reset mid-transaction drops the outstanding transaction with no response. The memory model is reset by the same rst_n.
- Accept at cycle T leads to mem_req_valid high from T+1.
- With mem_req_ready at T+1 and mem_rsp_valid at T+2, the rsp pulse is at T+2 and IDLE returns at T+3.
- Minimum period is 3 cycles per transaction. No new accept is possible in the cycle a response is routed.
- mem_rsp_valid in the same cycle as the mem_req handshake is a protocol violation. The memory must respond no earlier than the next cycle.
- Simultaneous valids in IDLE: exactly one ready, decided by the priority rule above.

## Test plan
- **Single fetch:**
  - Stimulus: if_req_valid with addr 0x1000. Memory ready immediately and returns 0x00500093 one cycle later.
  - Required: if_req_ready at T; mem_addr = 0x1000 and mem_we = 0 at T+1; if_rsp_valid with data 0x00500093 at T+2; d_rsp_valid never asserted.
- **Store path:**
  - Stimulus: d_req with addr 0x2008, we = 1, wdata 0xDEADBEEF, wstrb 0x0F. Memory holds mem_req_ready low for 3 cycles.
  - Required: mem fields stable through the stall; d_rsp_valid one cycle after the ack.
- **Priority and starvation, MAX_WAIT = 4:**
  - Stimulus: both valids held continuously.
  - Required grant order is D, D, D, D, F, D, D, D, D, F.
  - Required: starve_cnt returns to 0 after each F.
- **Stray response:**
  - Stimulus: mem_rsp_valid pulsed while IDLE, then while in REQ.
  - Required: no if/d rsp_valid, and the state is unchanged.
- **Reset mid-operation:**
  - Stimulus: rst_n asserted low asynchronously during WAIT_RSP, between clock edges.
  - Required: busy and mem_req_valid drop immediately; readies 0; after release, a fresh fetch completes normally with no leftover response.
- **Back-to-back loads:**
  - Stimulus: data loads to 0x3000 and 0x3008 queued.
  - Required: second accept exactly one cycle after the first response; correct data is routed for each.
